crop_resize: RTL and testbench
==============================

Name: crop_resize

Overview:
- Downstream consumer of the bounding-box stage.
- On start, latches the box (xMin/xMax/yMin/yMax) and reads the source image from the same column-major RGB memory.
- Produces an OUT_W x OUT_H nearest-neighbour resampled crop; each output pixel is the sum R+G+B.
- Output is written column-major into an output buffer, which feeds the classifier stage.

Parameters:
- WIDTH, 100, source image width in pixels.
- HEIGHT, 100, source image height in pixels; source address = x*HEIGHT*3 + row*3 + channel (R=0, G=1, B=2).
- OUT_W, 28, output width in pixels (>=1).
- OUT_H, 28, output height in pixels (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request; sampled in IDLE/DONE
- done  out  1  high while in DONE
- xMin  in  11  leftmost foreground column
- xMax  in  11  rightmost foreground column
- yMin  in  11  top foreground row*3 (R position)
- yMax  in  11  bottom foreground row*3 (R position)
- rd_addr  out  24  source memory address
- rddata  in  16  source data, valid one cycle after rd_addr (synchronous RAM)
- wr_addr  out  16  output buffer address = ox*OUT_H + oy
- wr_data  out  18  R+G+B, zero-extended, no saturation
- wr_en  out  1  output write strobe

Behaviour:
- Reset (async, any state): state=IDLE; done, wr_en, rd_addr, wr_addr, wr_data, all counters/accumulators = 0.
- IDLE: start=1 latches box inputs and computes BW=xMax-xMin+1, BH=(yMax-yMin)/3+1; sets ox=oy=0, sx=xMin, sy3=yMin, errX=errY=0; goes to RD0.
- Invalid box: if xMin>xMax or yMin>yMax, go to ZERO instead of RD0.
- ZERO: one write per cycle of wr_data=0 over wr_addr 0..OUT_W*OUT_H-1; rd_addr held 0, no reads; then DONE.
- RD0: rd_addr=sx*HEIGHT*3+sy3.
- RD1: rd_addr=base+1; sum<=rddata (R).
- RD2: rd_addr=base+2; sum<=sum+G.
- WR: wr_en=1 for exactly this cycle; wr_data=sum+rddata (B), combinational; wr_addr=ox*OUT_H+oy.
- Minimum 5 cycles per output pixel.
- ADVY, entry: if oy==OUT_H-1, go to ADVX. Otherwise oy++, errY+=BH, stay in ADVY.
- ADVY, loop: while errY>=OUT_H, one subtraction per cycle: errY-=OUT_H, sy3+=3. When errY<OUT_H, go to RD0.
- ADVX: oy=0, sy3=yMin, errY=0. If ox==OUT_W-1, go to DONE. Otherwise ox++, errX+=BW, then loop one cycle per step while errX>=OUT_W: errX-=OUT_W, sx++. Then RD0.
- Required mapping (bench checks against this): sx = xMin + floor(ox*BW/OUT_W); row = yMin/3 + floor(oy*BH/OUT_H).
- Sampled pixels always lie inside the box: sx<=xMax, sy3<=yMax.
- DONE: done=1, wr_en=0. start=1 re-latches the box and restarts exactly as from IDLE; done drops the next cycle.
- start outside IDLE/DONE is ignored.
- Box inputs are sampled only at start; changes mid-run have no effect.
- Exactly OUT_W*OUT_H writes per run, in strictly increasing wr_addr order, no duplicates.
- Arithmetic: errX/errY 12 bits; sum 18 bits.

Test Plan:
- OUT_W=OUT_H=4; box x 10..13, rows 20..23 (yMin=60, yMax=69); pixel (x,row) has R=x, G=row, B=1 -> 16 writes; wr_addr k=ox*4+oy carries (10+ox)+(20+oy)+1; done rises after the last WR.
- Downscale: OUT 4x4, box x 0..7, rows 0..7 -> samples columns 0,2,4,6 and rows 0,2,4,6; wr_addr 5 (ox=1, oy=1) = value at (2,2).
- Upscale: OUT 4x4, box x 50..51, rows 5..6 -> columns 50,50,51,51 and rows 5,5,6,6; wr_data repeats in pairs.
- Empty box: xMin=99, xMax=0 (reset values of the box stage) -> 16 writes of 0 on consecutive cycles, no rd_addr change, then done=1.
- Reset mid-run: rst_n low after the 7th write -> same cycle wr_en=0, done=0; after release, start gives a full 16-write run from wr_addr 0.
- Restart in DONE: start with a new box -> done=0 next cycle, and the new run's data matches the new box; also, start pulsed mid-run is ignored.

Source files
------------

// File: rtl/crop_resize.sv
// Nearest-neighbour crop-and-resize of a bounding box from a column-major RGB image.
// Each output pixel is R+G+B, written column-major into the classifier input buffer.
module crop_resize #(
  parameter int unsigned WIDTH  = 100,
  parameter int unsigned HEIGHT = 100,
  parameter int unsigned OUT_W  = 28,
  parameter int unsigned OUT_H  = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  input  logic [10:0] xMin,
  input  logic [10:0] xMax,
  input  logic [10:0] yMin,
  input  logic [10:0] yMax,
  output logic [23:0] rd_addr,
  input  logic [15:0] rddata,
  output logic [15:0] wr_addr,
  output logic [17:0] wr_data,
  output logic        wr_en
);

  localparam int unsigned CRD_W      = 11;
  localparam int unsigned ERR_W      = 12;
  localparam int unsigned SUM_W      = 18;
  localparam int unsigned IDX_W      = 16;
  localparam int unsigned RADDR_W    = 24;
  localparam int unsigned ROW_STRIDE = HEIGHT * 3;
  localparam int unsigned N_PIX      = OUT_W * OUT_H;

  typedef enum logic [3:0] {
    S_IDLE, S_ZERO, S_RD0, S_RD1, S_RD2, S_WR,
    S_ADVY, S_ADVY_LP, S_ADVX, S_ADVX_LP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CRD_W-1:0]   ymin_q, ymin_d;
  logic [ERR_W-1:0]   bw_q, bw_d, bh_q, bh_d;
  logic [IDX_W-1:0]   ox_q, ox_d, oy_q, oy_d, zcnt_q, zcnt_d;
  logic [CRD_W-1:0]   sx_q, sx_d, sy3_q, sy3_d;
  logic [ERR_W-1:0]   errx_q, errx_d, erry_q, erry_d;
  logic [SUM_W-1:0]   sum_q, sum_d;

  logic               box_bad;
  logic [ERR_W-1:0]   bw_new, bh_new;
  logic [ERR_W-1:0]   errx_add, errx_sub, erry_add, erry_sub;
  logic [RADDR_W-1:0] base_addr;
  logic [IDX_W-1:0]   pix_addr;

  assign box_bad   = (xMin > xMax) || (yMin > yMax);
  assign bw_new    = ERR_W'(xMax) - ERR_W'(xMin) + ERR_W'(1);
  assign bh_new    = ERR_W'((yMax - yMin) / 11'd3) + ERR_W'(1);
  assign errx_add  = errx_q + bw_q;
  assign errx_sub  = errx_q - ERR_W'(OUT_W);
  assign erry_add  = erry_q + bh_q;
  assign erry_sub  = erry_q - ERR_W'(OUT_H);
  assign base_addr = RADDR_W'(32'(sx_q) * ROW_STRIDE + 32'(sy3_q));
  assign pix_addr  = IDX_W'(32'(ox_q) * OUT_H + 32'(oy_q));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ymin_q  <= '0;
      bw_q    <= '0;
      bh_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      zcnt_q  <= '0;
      sx_q    <= '0;
      sy3_q   <= '0;
      errx_q  <= '0;
      erry_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ymin_q  <= ymin_d;
      bw_q    <= bw_d;
      bh_q    <= bh_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      zcnt_q  <= zcnt_d;
      sx_q    <= sx_d;
      sy3_q   <= sy3_d;
      errx_q  <= errx_d;
      erry_q  <= erry_d;
      sum_q   <= sum_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    ymin_d  = ymin_q;
    bw_d    = bw_q;
    bh_d    = bh_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    zcnt_d  = zcnt_q;
    sx_d    = sx_q;
    sy3_d   = sy3_q;
    errx_d  = errx_q;
    erry_d  = erry_q;
    sum_d   = sum_q;
    done    = 1'b0;
    wr_en   = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          ymin_d  = yMin;
          bw_d    = bw_new;
          bh_d    = bh_new;
          ox_d    = '0;
          oy_d    = '0;
          zcnt_d  = '0;
          sx_d    = xMin;
          sy3_d   = yMin;
          errx_d  = '0;
          erry_d  = '0;
          state_d = box_bad ? S_ZERO : S_RD0;
        end
      end
      S_ZERO: begin
        wr_en   = 1'b1;
        wr_addr = zcnt_q;
        zcnt_d  = zcnt_q + IDX_W'(1);
        if (zcnt_q == IDX_W'(N_PIX - 1)) state_d = S_DONE;
      end
      S_RD0: begin
        rd_addr = base_addr;
        state_d = S_RD1;
      end
      S_RD1: begin
        rd_addr = base_addr + RADDR_W'(1);
        sum_d   = SUM_W'(rddata);
        state_d = S_RD2;
      end
      S_RD2: begin
        rd_addr = base_addr + RADDR_W'(2);
        sum_d   = sum_q + SUM_W'(rddata);
        state_d = S_WR;
      end
      S_WR: begin
        wr_en   = 1'b1;
        wr_addr = pix_addr;
        wr_data = sum_q + SUM_W'(rddata);
        state_d = S_ADVY;
      end
      S_ADVY: begin
        if (oy_q == IDX_W'(OUT_H - 1)) begin
          state_d = S_ADVX;
        end else begin
          oy_d    = oy_q + IDX_W'(1);
          erry_d  = erry_add;
          state_d = (erry_add >= ERR_W'(OUT_H)) ? S_ADVY_LP : S_RD0;
        end
      end
      S_ADVY_LP: begin
        erry_d  = erry_sub;
        sy3_d   = sy3_q + CRD_W'(3);
        state_d = (erry_sub >= ERR_W'(OUT_H)) ? S_ADVY_LP : S_RD0;
      end
      S_ADVX: begin
        oy_d   = '0;
        sy3_d  = ymin_q;
        erry_d = '0;
        if (ox_q == IDX_W'(OUT_W - 1)) begin
          state_d = S_DONE;
        end else begin
          ox_d    = ox_q + IDX_W'(1);
          errx_d  = errx_add;
          state_d = (errx_add >= ERR_W'(OUT_W)) ? S_ADVX_LP : S_RD0;
        end
      end
      S_ADVX_LP: begin
        errx_d = errx_sub;
        // Never step the source column past the image edge
        if (sx_q < CRD_W'(WIDTH - 1)) sx_d = sx_q + CRD_W'(1);
        state_d = (errx_sub >= ERR_W'(OUT_W)) ? S_ADVX_LP : S_RD0;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_crop_resize.sv
// Randomised scoreboard bench for crop_resize with a 4x4 output and a 100x100 source.
module tb_crop_resize;

  localparam int unsigned W      = 100;
  localparam int unsigned H      = 100;
  localparam int unsigned OW     = 4;
  localparam int unsigned OH     = 4;
  localparam int unsigned NPIX   = OW * OH;
  localparam int unsigned STRIDE = H * 3;
  localparam int unsigned MEMSZ  = W * H * 3;
  localparam int          BUDGET = 3000;

  typedef struct packed {
    logic [15:0] addr;
    logic [17:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [10:0] xMin, xMax, yMin, yMax;
  logic [23:0] rd_addr;
  logic [15:0] rddata;
  logic [15:0] wr_addr;
  logic [17:0] wr_data;
  logic        wr_en;

  logic [15:0] mem [MEMSZ];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;

  crop_resize #(.WIDTH(W), .HEIGHT(H), .OUT_W(OW), .OUT_H(OH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .rd_addr(rd_addr), .rddata(rddata),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous source RAM: data appears one cycle after the address
  always @(posedge clk)
    rddata <= (rd_addr < 24'(MEMSZ)) ? mem[int'(rd_addr)] : 16'd0;

  // Monitor: every write strobe is matched against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && wr_en === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            errors++;
            $display("FAIL pixel_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                     wr_addr, wr_data, e.addr, e.data);
          end
        end
        wr_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] px_sum(input int x, input int row);
    int a;
    a = x * STRIDE + row * 3;
    return 18'(mem[a]) + 18'(mem[a + 1]) + 18'(mem[a + 2]);
  endfunction

  // Reference: nearest-neighbour map from output grid to source box
  task automatic push_expected(input int x0, input int x1, input int r0, input int r1);
    exp_t e;
    if (x0 > x1 || r0 > r1) begin
      for (int k = 0; k < NPIX; k++) begin
        e.addr = 16'(k);
        e.data = 18'd0;
        sb.push_back(e);
      end
    end else begin
      int bw, bh, sx, row;
      bw = x1 - x0 + 1;
      bh = r1 - r0 + 1;
      for (int ox = 0; ox < OW; ox++)
        for (int oy = 0; oy < OH; oy++) begin
          sx  = x0 + (ox * bw) / OW;
          row = r0 + (oy * bh) / OH;
          e.addr = 16'(ox * OH + oy);
          e.data = px_sum(sx, row);
          sb.push_back(e);
        end
    end
  endtask

  task automatic set_box(input int x0, input int x1, input int r0, input int r1);
    xMin = 11'(x0);
    xMax = 11'(x1);
    yMin = 11'(r0 * 3);
    yMax = 11'(r1 * 3);
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (done !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic run(input int x0, input int x1, input int r0, input int r1,
                     input bit poke, input string name);
    set_box(x0, x1, r0, r1);
    push_expected(x0, x1, r0, r1);
    wr_cnt = 0;
    kick();
    check({name, "_busy"}, 64'(done), 64'd0);
    if (poke) begin
      repeat (15) @(posedge clk);
      #1 set_box(0, 99, 0, 99);
      kick();
    end
    wait_done(name);
    check({name, "_count"}, 64'(wr_cnt), 64'(NPIX));
    check({name, "_left"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic fill_pattern();
    for (int x = 0; x < W; x++)
      for (int r = 0; r < H; r++) begin
        mem[x * STRIDE + r * 3]     = 16'(x);
        mem[x * STRIDE + r * 3 + 1] = 16'(r);
        mem[x * STRIDE + r * 3 + 2] = 16'd1;
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < MEMSZ; i++) mem[i] = 16'($urandom);
  endtask

  initial begin
    int bad, cyc, x0, x1, r0, r1, t;
    rst_n = 1'b0;
    start = 1'b0;
    set_box(0, 0, 0, 0);
    fill_pattern();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({done, wr_en, rd_addr, wr_addr, wr_data}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_done", 64'(done), 64'd0);

    run(10, 13, 20, 23, 1'b0, "pattern");

    // Asynchronous reset after the seventh write of a run
    set_box(10, 13, 20, 23);
    push_expected(10, 13, 20, 23);
    wr_cnt = 0;
    kick();
    cyc = 0;
    while (wr_cnt < 7 && cyc < BUDGET) begin
      @(posedge clk);
      cyc++;
    end
    check("rst_reach7", 64'(wr_cnt), 64'd7);
    #1 rst_n = 1'b0;
    #1 check("rst_async", 64'({done, wr_en, rd_addr, wr_addr, wr_data}), 64'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run(10, 13, 20, 23, 1'b0, "post_rst");

    fill_random();
    run(0, 7, 0, 7, 1'b0, "downscale");
    run(50, 51, 5, 6, 1'b0, "upscale");

    // Empty box: zero writes back to back with no source reads
    set_box(99, 0, 0, 0);
    push_expected(99, 0, 0, 0);
    wr_cnt = 0;
    kick();
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      if (!(wr_en === 1'b1 && rd_addr === 24'd0)) bad++;
    end
    check("zero_consec", 64'(bad), 64'd0);
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_count", 64'(wr_cnt), 64'(NPIX));
    sb.delete();

    run(30, 40, 20, 31, 1'b1, "restart_poke");

    for (int i = 0; i < 8; i++) begin
      x0 = int'($urandom_range(0, W - 1));
      x1 = int'($urandom_range(x0, W - 1));
      r0 = int'($urandom_range(0, H - 1));
      r1 = int'($urandom_range(r0, H - 1));
      if (i == 5 && x0 != x1) begin
        t = x0; x0 = x1; x1 = t;
      end
      run(x0, x1, r0, r1, i[0], $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
